module_leds_mode: RTL
=====================

MODULE_LEDS_MODE -- requirements
Module: module_leds_mode

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of button/switch/LED channels (1..16).
REQ-002 SHALL have parameter W, default 4: switches and LEDs per channel (1..16).
REQ-003 SHALL have parameter DEB_CYCLES, default 10000: clock cycles a synchronised button level must be stable to be accepted (>=2).
REQ-004 SHALL have parameter BLINK_HALF, default 25000000: blink half-period in clock cycles (>=1); used only with LEDS_BLINK_EN.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port push_button_i  input  N_CH  raw asynchronous buttons; bit c belongs to channel c.
REQ-008 SHALL have port sw_i  input  N_CH*W  raw switches; bits [c*W +: W] belong to channel c.
REQ-009 SHALL have port leds_o  output  N_CH*W  registered LEDs; bits [c*W +: W] belong to channel c.
REQ-010 SHALL have port mode_o  output  2*N_CH  registered channel state; bits [2c +: 2] = 00 OFF, 01 LIVE, 10 HOLD.

Function
REQ-011 SHALL pass each push_button_i bit and each sw_i bit through a 2-flop synchroniser before use.
REQ-012 SHALL debounce each synchronised button per channel: counter resets on any level change, debounced level updates when the level has been stable DEB_CYCLES consecutive cycles.
REQ-013 SHALL generate a one-cycle press pulse per channel on a debounced 0->1 transition only; release generates nothing.
REQ-014 SHALL implement per channel a 3-state FSM: OFF -press-> LIVE -press-> HOLD -press-> OFF; no other transitions.
REQ-015 SHALL update the FSM state in the cycle after the press pulse; mode_o reflects it in the same cycle.
REQ-016 SHALL on entry to HOLD capture the synchronised switch value of that channel into a W-bit hold register, sampled in the press-pulse cycle.
REQ-017 SHALL drive leds_o per channel, registered one cycle after state: OFF -> all 0; LIVE -> synchronised switches; HOLD -> hold register.
REQ-018 SHALL treat channels independently; simultaneous presses on several channels all take effect in the same cycle.
REQ-019 SHALL ignore button pulses shorter than DEB_CYCLES cycles (bounce) completely.
REQ-020 SHALL keep debounce counters saturating at DEB_CYCLES (no wrap while a button is held).
REQ-021 SHALL make switch changes in HOLD invisible on leds_o until the channel returns to LIVE.

Reset
REQ-022 SHALL on rst_n low, asynchronously: all FSMs to OFF, leds_o = 0, mode_o = 0, hold registers = 0, debounced levels = 0, counters = 0, synchronisers = 0.
REQ-023 SHALL on rst_n low mid-operation (including during a debounce count or a held button) abandon the operation; a button still held at release of reset SHALL register as one press after DEB_CYCLES stable cycles.
REQ-024 SHALL release reset synchronously to clk (external requirement; block uses rst_n only as async clear).

Configuration
REQ-025 SHALL support macro LEDS_BLINK_EN: when defined, a free-running counter toggles a blink phase every BLINK_HALF cycles (phase 1 after reset), and HOLD channels output hold register AND phase; OFF and LIVE unaffected.
REQ-026 SHALL, without LEDS_BLINK_EN, instantiate no blink counter and output HOLD channels steadily; BLINK_HALF unused.

Verification (N_CH=4, W=4, DEB_CYCLES=4, BLINK_HALF=8)
REQ-027 SHALL cover: reset held, sw_i=16'hF731, buttons 0 -> leds_o=0, mode_o=0 throughout.
REQ-028 SHALL cover: push_button_i[0] held 10 cycles, sw[3:0]=4'h1 -> mode_o[1:0]=01, leds_o[3:0]=4'h1, other channels 0.
REQ-029 SHALL cover: channel 0 LIVE, second press, then sw[3:0] 4'h1->4'hA -> mode_o[1:0]=10, leds_o[3:0] stays 4'h1; third press -> 00 and leds 0.
REQ-030 SHALL cover: push_button_i[2] bouncing 1-cycle pulses x5 then low -> mode_o, leds_o unchanged.
REQ-031 SHALL cover: buttons 1 and 3 rise same cycle, held 10 cycles -> both mode fields 01 in same cycle.
REQ-032 SHALL cover (LEDS_BLINK_EN): channel 0 HOLD at 4'hF -> leds_o[3:0] alternates 4'hF/4'h0 every 8 cycles; rst_n pulse mid-blink -> all outputs 0 immediately.

Source files
------------

// File: rtl/module_leds_mode.sv
// -----------------------------------------------------------------------------
// module_leds_mode
//
// Per-channel button-driven LED mode controller. Each channel owns one push
// button, W switches and W LEDs. Every press of the channel's button advances
// a three-state machine:
//
//   OFF  --press-->  LIVE  --press-->  HOLD  --press-->  OFF
//
//   OFF  : LEDs dark
//   LIVE : LEDs follow the (synchronised) switches
//   HOLD : LEDs show the switch value captured on entry to HOLD
//
// Buttons and switches are raw asynchronous inputs. Both pass through a
// 2-flop synchroniser. Buttons are then debounced and edge-detected so that
// only a clean, stable 0->1 transition produces a single press pulse.
//
// Optional feature (compile-time macro LEDS_BLINK_EN):
//   When defined, a free-running counter toggles a blink phase every
//   BLINK_HALF cycles (phase = 1 right after reset). HOLD channels then show
//   (hold value AND phase), so a held pattern blinks. OFF and LIVE channels
//   are unaffected. Without the macro no blink counter exists and HOLD
//   channels are steady; BLINK_HALF is then unused.
//
// Parameters:
//   N_CH       : number of channels (1..16)
//   W          : switches / LEDs per channel (1..16)
//   DEB_CYCLES : cycles a synchronised button level must be stable (>=2)
//   BLINK_HALF : blink half-period in cycles (>=1), LEDS_BLINK_EN only
//
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low clear (release must be
//                   synchronous to clk, provided externally)
//   push_button_i : raw buttons, bit c -> channel c
//   sw_i          : raw switches, bits [c*W +: W] -> channel c
//   leds_o        : registered LEDs, bits [c*W +: W] -> channel c
//   mode_o        : registered channel state, bits [2c +: 2]
//                   00 OFF, 01 LIVE, 10 HOLD (also serves as FSM debug view)
// -----------------------------------------------------------------------------
module module_leds_mode #(
  parameter int N_CH       = 4,
  parameter int W          = 4,
  parameter int DEB_CYCLES = 10000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     push_button_i,
  input  logic [N_CH*W-1:0]   sw_i,
  output logic [N_CH*W-1:0]   leds_o,
  output logic [2*N_CH-1:0]   mode_o
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_LIVE = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // Debounce counter holds "cycles the current synchronised level has been
  // stable", saturating at DEB_CYCLES.
  localparam int             CW        = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_PRE   = CW'(DEB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0]   btn_meta;
  logic [N_CH-1:0]   btn_sync;
  logic [N_CH*W-1:0] sw_meta;
  logic [N_CH*W-1:0] sw_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= push_button_i;
      btn_sync <= btn_meta;
      sw_meta  <= sw_i;
      sw_sync  <= sw_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce and press detection
  //
  // btn_last is the previous synchronised sample; a difference marks a level
  // change. On a change the counter restarts at 1 because the new level has
  // already been present for one cycle. When the counter is about to reach
  // DEB_CYCLES with no change, the level is accepted as the debounced level,
  // and a 0->1 acceptance emits a one-cycle press pulse. Once saturated the
  // counter parks, so a long hold never re-triggers.
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] btn_last;
  logic [CW-1:0]   deb_cnt [N_CH];
  logic [N_CH-1:0] deb_level;
  logic [N_CH-1:0] press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_last  <= '0;
      deb_level <= '0;
      press     <= '0;
      for (int c = 0; c < N_CH; c++) begin
        deb_cnt[c] <= '0;
      end
    end else begin
      btn_last <= btn_sync;
      for (int c = 0; c < N_CH; c++) begin
        press[c] <= 1'b0;
        if (btn_sync[c] != btn_last[c]) begin
          deb_cnt[c] <= CW'(1);
        end else begin
          if (deb_cnt[c] != CNT_MAX) begin
            deb_cnt[c] <= deb_cnt[c] + 1'b1;
          end
          if (deb_cnt[c] == CNT_PRE) begin
            deb_level[c] <= btn_sync[c];
            press[c]     <= btn_sync[c] & ~deb_level[c];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel mode FSM (state register + next-state logic)
  // ---------------------------------------------------------------------------
  state_t state_q [N_CH];
  state_t state_d [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= ST_OFF;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      if (press[c]) begin
        case (state_q[c])
          ST_OFF:  state_d[c] = ST_LIVE;
          ST_LIVE: state_d[c] = ST_HOLD;
          ST_HOLD: state_d[c] = ST_OFF;
          default: state_d[c] = ST_OFF;
        endcase
      end
    end
  end

  // mode_o is a direct view of the state registers.
  always_comb begin
    mode_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      mode_o[2*c +: 2] = state_q[c];
    end
  end

  // ---------------------------------------------------------------------------
  // Hold registers: captured in the press cycle that moves LIVE -> HOLD, so
  // the frozen value is exactly what LIVE was showing at the press.
  // ---------------------------------------------------------------------------
  logic [W-1:0] hold_q [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        hold_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (press[c] && (state_q[c] == ST_LIVE)) begin
          hold_q[c] <= sw_sync[c*W +: W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase (optional)
  // ---------------------------------------------------------------------------
  logic [W-1:0] hold_mask;

`ifdef LEDS_BLINK_EN
  localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign hold_mask = {W{blink_phase}};
`else
  assign hold_mask = {W{1'b1}};
`endif

  // ---------------------------------------------------------------------------
  // LED output register: follows the state one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_o <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        case (state_q[c])
          ST_LIVE: leds_o[c*W +: W] <= sw_sync[c*W +: W];
          ST_HOLD: leds_o[c*W +: W] <= hold_q[c] & hold_mask;
          default: leds_o[c*W +: W] <= '0;
        endcase
      end
    end
  end

endmodule
